// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: latches button presses and grants WALK then a
// flashing clearance phase inside a vehicle-red window, with a sticky safety fault.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_TIME  = 3,
  parameter int unsigned CLEAR_TIME = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic red,
  input  logic yellow,
  input  logic green,
  input  logic ped_btn,
  output logic walk,
  output logic dont_walk,
  output logic flash,
  output logic req_pending,
  output logic fault
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s2_dly_q, s2_dly_d;
  logic               red_dly_q, red_dly_d;
  logic               req_pending_q, req_pending_d;
  logic               fault_q, fault_d;
  logic               walk_q, walk_d;
  logic               dont_walk_q, dont_walk_d;
  logic               flash_q, flash_d;

  logic               press_c;
  logic               red_rise_c;
  logic               onehot_ok_c;
  logic               abort_c;

  always_comb begin
    press_c     = s2_q & ~s2_dly_q;
    red_rise_c  = red & ~red_dly_q;
    onehot_ok_c = ({red, yellow, green} == 3'b100) ||
                  ({red, yellow, green} == 3'b010) ||
                  ({red, yellow, green} == 3'b001);
    abort_c     = ~red | ~onehot_ok_c;
  end

  // Next-state, counter, request latch and registered lamp decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s1_d          = ped_btn;
    s2_d          = s1_q;
    s2_dly_d      = s2_q;
    red_dly_d     = red;
    fault_d       = fault_q | ~onehot_ok_c;
    req_pending_d = req_pending_q | press_c;
    walk_d        = 1'b0;
    dont_walk_d   = 1'b1;
    flash_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_pending_q && red_rise_c && onehot_ok_c && !fault_q) begin
          state_d       = WALK;
          cnt_d         = CNT_W'(WALK_TIME - 1);
          req_pending_d = 1'b0;
        end
      end
      WALK: begin
        if (abort_c) begin
          state_d = IDLE;
          cnt_d   = '0;
          fault_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLEAR_TIME - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (abort_c) begin
          state_d = IDLE;
          cnt_d   = '0;
          fault_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Lamps follow the state being entered so they are pure flop outputs
    unique case (state_d)
      WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      CLEAR: begin
        flash_d     = 1'b1;
        dont_walk_d = (state_q == CLEAR) ? ~dont_walk_q : 1'b1;
      end
      default: begin
        dont_walk_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s2_dly_q      <= 1'b0;
      red_dly_q     <= 1'b0;
      req_pending_q <= 1'b0;
      fault_q       <= 1'b0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      flash_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s2_dly_q      <= s2_dly_d;
      red_dly_q     <= red_dly_d;
      req_pending_q <= req_pending_d;
      fault_q       <= fault_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      flash_q       <= flash_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign flash       = flash_q;
  assign req_pending = req_pending_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: instance A uses default timing, instance B
// uses CLEAR_TIME=3 so a 6-cycle red overruns the clearance phase.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, red_a, yellow_a, green_a, btn_a;
  logic walk_a, dont_walk_a, flash_a, req_a, fault_a;
  logic reset_b, red_b, yellow_b, green_b, btn_b;
  logic walk_b, dont_walk_b, flash_b, req_b, fault_b;

  int total = 0;
  int bad   = 0;

  // {walk, dont_walk, flash, req_pending, fault}
  localparam logic [4:0] V_IDLE = 5'b01000;
  localparam logic [4:0] V_PEND = 5'b01010;
  localparam logic [4:0] V_WALK = 5'b10000;
  localparam logic [4:0] V_CLR1 = 5'b01100;
  localparam logic [4:0] V_CLR0 = 5'b00100;
  localparam logic [4:0] V_FLT  = 5'b01001;
  localparam logic [4:0] V_FLTP = 5'b01011;

  ped_crossing_ctrl #(.WALK_TIME(3), .CLEAR_TIME(2)) dut_a (
    .clk(clk), .reset(reset_a), .red(red_a), .yellow(yellow_a), .green(green_a),
    .ped_btn(btn_a), .walk(walk_a), .dont_walk(dont_walk_a), .flash(flash_a),
    .req_pending(req_a), .fault(fault_a)
  );

  ped_crossing_ctrl #(.WALK_TIME(3), .CLEAR_TIME(3)) dut_b (
    .clk(clk), .reset(reset_b), .red(red_b), .yellow(yellow_b), .green(green_b),
    .ped_btn(btn_b), .walk(walk_b), .dont_walk(dont_walk_b), .flash(flash_b),
    .req_pending(req_b), .fault(fault_b)
  );

  task automatic check(input bit b, input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    obs = b ? {walk_b, dont_walk_b, flash_b, req_b, fault_b}
            : {walk_a, dont_walk_a, flash_a, req_a, fault_a};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic run(input bit b, input int n, input logic [4:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(b, exp, tag);
    end
  endtask

  task automatic lights(input bit b, input logic r, input logic y, input logic g);
    if (b) begin
      red_b = r; yellow_b = y; green_b = g;
    end else begin
      red_a = r; yellow_a = y; green_a = g;
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    btn_a = 1'b0;   btn_b = 1'b0;
    lights(0, 1'b0, 1'b0, 1'b1);
    lights(1, 1'b0, 1'b0, 1'b1);
    #1;
    check(0, V_IDLE, "reset_a");
    check(1, V_IDLE, "reset_b");
    run(0, 2, V_IDLE, "reset_hold");
    reset_a = 1'b0;

    // Normal grant
    btn_a = 1'b1;
    run(0, 1, V_IDLE, "n_sync1");
    btn_a = 1'b0;
    run(0, 1, V_IDLE, "n_sync2");
    run(0, 3, V_PEND, "n_pending");
    lights(0, 0, 1, 0);
    run(0, 3, V_PEND, "n_yellow");
    lights(0, 1, 0, 0);
    run(0, 3, V_WALK, "n_walk");
    run(0, 1, V_CLR1, "n_clear1");
    run(0, 1, V_CLR0, "n_clear2");
    run(0, 1, V_IDLE, "n_idle");
    lights(0, 0, 0, 1);

    // No request over three light cycles
    for (int k = 0; k < 3; k++) begin
      run(0, 5, V_IDLE, "nr_green");
      lights(0, 0, 1, 0);
      run(0, 3, V_IDLE, "nr_yellow");
      lights(0, 1, 0, 0);
      run(0, 6, V_IDLE, "nr_red");
      lights(0, 0, 0, 1);
    end

    // Press during red waits for the next red rise
    run(0, 5, V_IDLE, "pr_green");
    lights(0, 0, 1, 0);
    run(0, 3, V_IDLE, "pr_yellow");
    lights(0, 1, 0, 0);
    run(0, 1, V_IDLE, "pr_redrise");
    btn_a = 1'b1;
    run(0, 1, V_IDLE, "pr_sync1");
    btn_a = 1'b0;
    run(0, 1, V_IDLE, "pr_sync2");
    run(0, 3, V_PEND, "pr_nomidred");
    lights(0, 0, 0, 1);
    run(0, 5, V_PEND, "pr_green2");
    lights(0, 0, 1, 0);
    run(0, 3, V_PEND, "pr_yellow2");
    lights(0, 1, 0, 0);
    run(0, 3, V_WALK, "pr_walk");
    run(0, 1, V_CLR1, "pr_clear1");
    run(0, 1, V_CLR0, "pr_clear2");
    run(0, 1, V_IDLE, "pr_idle");
    lights(0, 0, 0, 1);
    run(0, 5, V_IDLE, "pr_green3");
    lights(0, 0, 1, 0);
    run(0, 3, V_IDLE, "pr_yellow3");
    lights(0, 1, 0, 0);
    run(0, 6, V_IDLE, "pr_onegrant");
    lights(0, 0, 0, 1);

    // Button held for 20 cycles gives one request and one grant
    btn_a = 1'b1;
    run(0, 2, V_IDLE, "hb_sync");
    run(0, 3, V_PEND, "hb_pending");
    lights(0, 0, 1, 0);
    run(0, 3, V_PEND, "hb_yellow");
    lights(0, 1, 0, 0);
    run(0, 3, V_WALK, "hb_walk");
    run(0, 1, V_CLR1, "hb_clear1");
    run(0, 1, V_CLR0, "hb_clear2");
    run(0, 1, V_IDLE, "hb_idle");
    lights(0, 0, 0, 1);
    run(0, 5, V_IDLE, "hb_noreq");
    lights(0, 0, 1, 0);
    run(0, 1, V_IDLE, "hb_lastheld");
    btn_a = 1'b0;
    run(0, 2, V_IDLE, "hb_released");
    lights(0, 1, 0, 0);
    run(0, 6, V_IDLE, "hb_nogrant2");
    lights(0, 0, 0, 1);

    // Reset in WALK cycle 2 drops WALK at once and loses the request
    btn_a = 1'b1;
    run(0, 1, V_IDLE, "rs_sync1");
    btn_a = 1'b0;
    run(0, 1, V_IDLE, "rs_sync2");
    run(0, 3, V_PEND, "rs_pending");
    lights(0, 0, 1, 0);
    run(0, 3, V_PEND, "rs_yellow");
    lights(0, 1, 0, 0);
    run(0, 2, V_WALK, "rs_walk");
    reset_a = 1'b1;
    #1;
    check(0, V_IDLE, "rs_async");
    run(0, 1, V_IDLE, "rs_held");
    reset_a = 1'b0;
    run(0, 3, V_IDLE, "rs_after");
    lights(0, 0, 0, 1);
    run(0, 5, V_IDLE, "rs_green");

    // Non-one-hot lights raise a sticky fault that blocks later grants
    lights(0, 1, 0, 1);
    run(0, 1, V_FLT, "oh_fault");
    lights(0, 0, 0, 1);
    btn_a = 1'b1;
    run(0, 1, V_FLT, "oh_sync1");
    btn_a = 1'b0;
    run(0, 1, V_FLT, "oh_sync2");
    run(0, 3, V_FLTP, "oh_latched");
    lights(0, 0, 1, 0);
    run(0, 3, V_FLTP, "oh_yellow");
    lights(0, 1, 0, 0);
    run(0, 6, V_FLTP, "oh_nogrant");
    lights(0, 0, 0, 1);
    run(0, 2, V_FLTP, "oh_sticky");

    // Clearance overrun on instance B: red falls in the last CLEAR cycle
    reset_b = 1'b0;
    btn_b = 1'b1;
    run(1, 1, V_IDLE, "ov_sync1");
    btn_b = 1'b0;
    run(1, 1, V_IDLE, "ov_sync2");
    run(1, 3, V_PEND, "ov_pending");
    lights(1, 0, 1, 0);
    run(1, 3, V_PEND, "ov_yellow");
    lights(1, 1, 0, 0);
    run(1, 3, V_WALK, "ov_walk");
    run(1, 1, V_CLR1, "ov_clear1");
    run(1, 1, V_CLR0, "ov_clear2");
    run(1, 1, V_CLR1, "ov_clear3");
    lights(1, 0, 0, 1);
    run(1, 1, V_FLT, "ov_abort");
    run(1, 4, V_FLT, "ov_green");
    btn_b = 1'b1;
    run(1, 1, V_FLT, "ov_sync1b");
    btn_b = 1'b0;
    run(1, 1, V_FLT, "ov_sync2b");
    run(1, 3, V_FLTP, "ov_latched");
    lights(1, 0, 1, 0);
    run(1, 3, V_FLTP, "ov_yellow2");
    lights(1, 1, 0, 0);
    run(1, 6, V_FLTP, "ov_nogrant");
    lights(1, 0, 0, 1);
    run(1, 2, V_FLTP, "ov_sticky");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
